// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue controller in front of the ALU result mux.
// Takes operations on a valid/ready handshake and latches them. It drives the
// add, boolean and shift units, sequences the multi-cycle shifter, and raises
// a one-hot select into the result mux, then out_valid when the mux output
// lands.
// Optional build macro: ALU_ISSUE_PERF_CNT_EN adds saturating 16-bit issue
// counters per operation class (cnt_add, cnt_bool, cnt_shift, cnt_illegal).
module alu_issue_ctrl #(
  parameter int WIDTH     = 32,
  parameter int SHIFT_LAT = 2,   // 1..15
  parameter int MUX_LAT   = 1    // 1..4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             add_sub,
  output logic [1:0]       bool_fn,
  output logic [1:0]       shift_fn,
  output logic             shift_start,
  output logic [2:0]       en,
  output logic             out_valid,
  output logic             illegal_op,
  output logic             busy
`ifdef ALU_ISSUE_PERF_CNT_EN
  ,
  output logic [15:0]      cnt_add,
  output logic [15:0]      cnt_bool,
  output logic [15:0]      cnt_shift,
  output logic [15:0]      cnt_illegal
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT_WAIT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SHIFT_LAT - 1);

  state_t             state_q, state_d;
  logic [3:0]         op_q;
  logic [3:0]         cnt_q;
  logic [MUX_LAT-1:0] vpipe_q;
  logic               op_is_add, op_is_bool, op_is_shift;
  logic               ready_int, accept, issue;

  // Classify the latched opcode; anything with bit 3 set is illegal.
  assign op_is_add   = (op_q == 4'd0) || (op_q == 4'd1);
  assign op_is_bool  = (op_q >= 4'd2) && (op_q <= 4'd4);
  assign op_is_shift = (op_q >= 4'd5) && (op_q <= 4'd7);

  // Readiness depends only on registered state; reset forces it low.
  assign ready_int = (state_q == IDLE)
                  || (state_q == EXEC && !op_is_shift)
                  || (state_q == SHIFT_WAIT && cnt_q == 4'd0);
  assign in_ready  = ready_int && !rst;
  assign accept    = in_valid && in_ready;

  assign busy      = (state_q != IDLE);
  assign out_valid = vpipe_q[MUX_LAT-1];

  // Next-state and decoded unit controls from the current state.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    en          = 3'b000;
    shift_start = 1'b0;
    issue       = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = EXEC;
      end
      EXEC: begin
        if (op_is_shift) begin
          shift_start = 1'b1;
          state_d     = SHIFT_WAIT;
        end else begin
          en      = {1'b0, op_is_bool, op_is_add};
          issue   = 1'b1;
          state_d = in_valid ? EXEC : IDLE;
        end
      end
      SHIFT_WAIT: begin
        if (cnt_q == 4'd0) begin
          en      = 3'b100;
          issue   = 1'b1;
          state_d = in_valid ? EXEC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Shifter latency counter: loaded when the shift starts, counts down to issue.
  always_ff @(posedge clk) begin
    if (rst)                                    cnt_q <= 4'd0;
    else if (state_q == EXEC && op_is_shift)    cnt_q <= CNT_INIT;
    else if (state_q == SHIFT_WAIT && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
  end

  // Operation registers; each function field changes only when its class is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= 4'd0;
      op_a     <= '0;
      op_b     <= '0;
      add_sub  <= 1'b0;
      bool_fn  <= 2'd0;
      shift_fn <= 2'd0;
    end else if (accept) begin
      op_q <= in_op;
      op_a <= in_a;
      op_b <= in_b;
      case (in_op)
        4'd0, 4'd1: add_sub  <= in_op[0];
        4'd2:       bool_fn  <= 2'd0;
        4'd3:       bool_fn  <= 2'd1;
        4'd4:       bool_fn  <= 2'd2;
        4'd5:       shift_fn <= 2'd0;
        4'd6:       shift_fn <= 2'd1;
        4'd7:       shift_fn <= 2'd2;
        default: ;
      endcase
    end
  end

  // Result-valid pipeline matching the mux latency.
  always_ff @(posedge clk) begin
    if (rst) vpipe_q <= '0;
    else     vpipe_q <= MUX_LAT'({vpipe_q, issue});
  end

  // Sticky illegal-opcode flag.
  always_ff @(posedge clk) begin
    if (rst)                   illegal_op <= 1'b0;
    else if (accept && in_op[3]) illegal_op <= 1'b1;
  end

`ifdef ALU_ISSUE_PERF_CNT_EN
  logic issue_illegal;
  assign issue_illegal = (state_q == EXEC) && op_q[3];

  // Saturating per-class issue counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_add     <= 16'd0;
      cnt_bool    <= 16'd0;
      cnt_shift   <= 16'd0;
      cnt_illegal <= 16'd0;
    end else begin
      if (en[0] && cnt_add != 16'hFFFF)         cnt_add     <= cnt_add + 16'd1;
      if (en[1] && cnt_bool != 16'hFFFF)        cnt_bool    <= cnt_bool + 16'd1;
      if (en[2] && cnt_shift != 16'hFFFF)       cnt_shift   <= cnt_shift + 16'd1;
      if (issue_illegal && cnt_illegal != 16'hFFFF) cnt_illegal <= cnt_illegal + 16'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and randomized bench for alu_issue_ctrl.
// The reference model is a per-cycle schedule: each accepted operation books
// its shifter start, issue cycle, ready window and result cycle. Each cycle,
// the bench compares the DUT against that schedule.
module tb_alu_issue_ctrl;
  localparam int WIDTH = 32;
  localparam int SL    = 2;
  localparam int ML    = 1;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a, in_b, op_a, op_b;
  logic             add_sub, shift_start, out_valid, illegal_op, busy;
  logic [1:0]       bool_fn, shift_fn;
  logic [2:0]       en;
`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [15:0]      cnt_add, cnt_bool, cnt_shift, cnt_illegal;
`endif

  alu_issue_ctrl #(.WIDTH(WIDTH), .SHIFT_LAT(SL), .MUX_LAT(ML)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .op_a(op_a), .op_b(op_b),
    .add_sub(add_sub), .bool_fn(bool_fn), .shift_fn(shift_fn),
    .shift_start(shift_start), .en(en), .out_valid(out_valid),
    .illegal_op(illegal_op), .busy(busy)
`ifdef ALU_ISSUE_PERF_CNT_EN
    , .cnt_add(cnt_add), .cnt_bool(cnt_bool), .cnt_shift(cnt_shift),
    .cnt_illegal(cnt_illegal)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  int         cyc = 0;
  int         ready_from = 0;
  int         busy_until = -1;
  int         last_rst = -100;
  int         issue_at[int];   // cycle -> class (0 add, 1 bool, 2 shift, 3 illegal)
  bit         start_at[int];   // cycle -> shifter start
  logic [31:0] m_a = '0, m_b = '0;
  logic        m_add_sub = 1'b0, m_ill = 1'b0;
  logic [1:0]  m_bool = '0, m_shift = '0;
  int          m_cnt[4] = '{0, 0, 0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle %0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int op_class(input logic [3:0] op);
    if (op <= 4'd1) return 0;
    if (op <= 4'd4) return 1;
    if (op <= 4'd7) return 2;
    return 3;
  endfunction

  function automatic logic [2:0] class_en(input int cl);
    case (cl)
      0: return 3'b001;
      1: return 3'b010;
      2: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Discard every booked event after cycle c (a reset abandons them).
  task automatic drop_future(input int c);
    int keys[$];
    foreach (issue_at[k]) if (k > c) keys.push_back(k);
    foreach (keys[i]) issue_at.delete(keys[i]);
    keys.delete();
    foreach (start_at[k]) if (k > c) keys.push_back(k);
    foreach (keys[i]) start_at.delete(keys[i]);
  endtask

  // One clock cycle: drive inputs, compare outputs against the schedule, advance the model.
  task automatic step(input logic r, input logic v, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input bit chk, output bit acc);
    bit         rdy;
    logic [2:0] e_en;
    int         cl;
    @(negedge clk);
    rst = r; in_valid = v; in_op = op; in_a = a; in_b = b;
    #1;
    rdy  = !r && (cyc >= ready_from);
    e_en = issue_at.exists(cyc) ? class_en(issue_at[cyc]) : 3'b000;
    if (chk) begin
      check("in_ready", in_ready, rdy);
      check("en", en, e_en);
      check("shift_start", shift_start, start_at.exists(cyc));
      check("out_valid", out_valid, issue_at.exists(cyc - ML) && (last_rst < cyc - ML));
      check("busy", busy, cyc <= busy_until);
      check("illegal_op", illegal_op, m_ill);
      check("op_a", op_a, m_a);
      check("op_b", op_b, m_b);
      check("add_sub", add_sub, m_add_sub);
      check("bool_fn", bool_fn, m_bool);
      check("shift_fn", shift_fn, m_shift);
`ifdef ALU_ISSUE_PERF_CNT_EN
      check("cnt_add", cnt_add, m_cnt[0]);
      check("cnt_bool", cnt_bool, m_cnt[1]);
      check("cnt_shift", cnt_shift, m_cnt[2]);
      check("cnt_illegal", cnt_illegal, m_cnt[3]);
`endif
    end
    acc = v && rdy;
    @(posedge clk);
    if (issue_at.exists(cyc)) begin
      cl = issue_at[cyc];
      if (m_cnt[cl] < 16'hFFFF) m_cnt[cl]++;
    end
    if (acc) begin
      cl  = op_class(op);
      m_a = a;
      m_b = b;
      case (op)
        4'd0, 4'd1: m_add_sub = op[0];
        4'd2, 4'd3, 4'd4: m_bool = 2'(op - 4'd2);
        4'd5, 4'd6, 4'd7: m_shift = 2'(op - 4'd5);
        default: m_ill = 1'b1;
      endcase
      if (cl == 2) begin
        start_at[cyc + 1]     = 1'b1;
        issue_at[cyc + 1 + SL] = 2;
        ready_from = cyc + 1 + SL;
        busy_until = cyc + 1 + SL;
      end else begin
        issue_at[cyc + 1] = cl;
        ready_from = cyc + 1;
        busy_until = cyc + 1;
      end
    end
    if (r) begin
      drop_future(cyc);
      ready_from = cyc + 1;
      busy_until = cyc;
      last_rst   = cyc;
      m_a = '0; m_b = '0; m_add_sub = 1'b0; m_bool = '0; m_shift = '0; m_ill = 1'b0;
      m_cnt = '{0, 0, 0, 0};
    end
    issue_at.delete(cyc - 10);
    start_at.delete(cyc - 10);
    cyc++;
  endtask

  function automatic logic [3:0] rand_op();
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(8, 15));
    return 4'($urandom_range(0, 7));
  endfunction

  initial begin
    bit          acc;
    logic        pv;
    logic [3:0]  pop;
    logic [31:0] pa, pb;

    // Reset: first cycle unchecked (DUT state still unknown), then checked.
    step(1, 0, 0, 0, 0, 0, acc);
    step(1, 1, 0, 0, 0, 1, acc);
    step(0, 0, 0, 0, 0, 1, acc);

    // ADD 5+7.
    step(0, 1, 4'd0, 32'd5, 32'd7, 1, acc);
    check("t1_accept", acc, 1);
    repeat (3) step(0, 0, 0, 0, 0, 1, acc);

    // AND then OR back to back.
    step(0, 1, 4'd2, 32'hF0F0, 32'h0FF0, 1, acc);
    step(0, 1, 4'd3, 32'h1234, 32'h4321, 1, acc);
    check("t2_back_to_back", acc, 1);
    repeat (3) step(0, 0, 0, 0, 0, 1, acc);

    // SRL followed by an ADD that is held until accepted.
    step(0, 1, 4'd6, 32'h8000_0000, 32'd3, 1, acc);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) step(0, 1, 4'd1, 32'd9, 32'd4, 1, acc);
    check("t3_held_add_accepted", acc, 1);
    repeat (3) step(0, 0, 0, 0, 0, 1, acc);

    // Illegal opcode, then ten legal operations held until accepted.
    step(0, 1, 4'hC, 32'd1, 32'd2, 1, acc);
    for (int n = 0; n < 10; n++) begin
      pop = 4'($urandom_range(0, 7));
      pa  = $urandom;
      pb  = $urandom;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) step(0, 1, pop, pa, pb, 1, acc);
      check("t4_legal_accepted", acc, 1);
    end
    repeat (4) step(0, 0, 0, 0, 0, 1, acc);

    // Reset during SHIFT_WAIT with one cycle left: the shift is abandoned.
    step(0, 1, 4'd7, 32'hDEAD_BEEF, 32'd5, 1, acc);
    check("t5_shift_accepted", acc, 1);
    step(0, 0, 0, 0, 0, 1, acc);
    step(1, 0, 0, 0, 0, 1, acc);
    repeat (6) step(0, 0, 0, 0, 0, 1, acc);

    // Randomized traffic with held offers and occasional resets.
    pv = 1'b0; pop = '0; pa = '0; pb = '0;
    for (int i = 0; i < 2000; i++) begin
      logic r;
      if (!pv) begin
        pv  = ($urandom_range(0, 9) < 7);
        pop = rand_op();
        pa  = $urandom;
        pb  = $urandom;
      end
      r = ($urandom_range(0, 99) == 0);
      step(r, pv, pop, pa, pb, 1, acc);
      pv = pv && !acc && !r;
    end
    repeat (6) step(0, 0, 0, 0, 0, 1, acc);

`ifdef ALU_ISSUE_PERF_CNT_EN
    // Counter saturation: 70000 back-to-back ADDs after a clean reset.
    step(1, 0, 0, 0, 0, 1, acc);
    for (int i = 0; i < 70000; i++) step(0, 1, 4'd0, i, 32'd1, 1, acc);
    step(0, 0, 0, 0, 0, 1, acc);
    check("t6_cnt_add_sat", cnt_add, 16'hFFFF);
    check("t6_cnt_bool", cnt_bool, 16'h0000);
    check("t6_cnt_shift", cnt_shift, 16'h0000);
    check("t6_cnt_illegal", cnt_illegal, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
